// File: rtl/irq_priority_ctrl.sv
// Eight-source edge-triggered interrupt controller: records rising edges as pending
// and presents the highest-priority unmasked one until the consumer acknowledges it.
module irq_priority_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] irq_q;
  logic [7:0] rise;
  logic [7:0] elig;
  logic [7:0] ack_clr;
  logic [7:0] pending_nxt;
  logic       irq_valid_nxt;
  logic [2:0] irq_id_nxt;
  logic [2:0] top_idx;

  assign rise = irq_in & ~irq_q;
  assign elig = pending & ~mask;

  // Ascending scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (elig[i]) begin
        top_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (|elig) ? REQ : IDLE;
      REQ:     state_nxt = ack ? GAP : REQ;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq_valid_nxt = 1'b0;
    irq_id_nxt    = 3'd0;
    ack_clr       = 8'h00;
    case (state)
      IDLE: begin
        if (|elig) begin
          irq_valid_nxt = 1'b1;
          irq_id_nxt    = top_idx;
        end
      end
      REQ: begin
        if (ack) begin
          ack_clr = 8'h01 << irq_id;
        end else begin
          irq_valid_nxt = irq_valid;
          irq_id_nxt    = irq_id;
        end
      end
      default: begin
        irq_valid_nxt = 1'b0;
        irq_id_nxt    = 3'd0;
      end
    endcase
  end

  // A rise on the acknowledge edge must survive the clear, so rise is OR-ed in last.
  assign pending_nxt = (pending & ~ack_clr) | rise;

  // irq_q resets high so lines already asserted at reset release do not look like new edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= 8'hFF;
      pending   <= 8'h00;
      irq_valid <= 1'b0;
      irq_id    <= 3'd0;
    end else begin
      irq_q     <= irq_in;
      pending   <= pending_nxt;
      irq_valid <= irq_valid_nxt;
      irq_id    <= irq_id_nxt;
    end
  end

endmodule
